// File: rtl/frame_scheduler.sv
// Frame scheduler: sequences BRAM-to-stream frames with inter-frame gaps and
// hands the BRAM to a loader only at frame boundaries.
//
//   state | meaning
//   IDLE  | no run active, waiting for a start or a load request
//   LOAD  | loader owns the BRAM, streaming disabled
//   RUN   | streaming a frame, counting handshaked beats
//   GAP   | idle cycles between frames of a run
module frame_scheduler #(
  parameter int FRAME_WORDS = 1040,
  parameter int CNT_W       = 16
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic             CFG_START,
  input  logic             CFG_STOP,
  input  logic [CNT_W-1:0] CFG_NUM_FRAMES,
  input  logic [CNT_W-1:0] CFG_GAP,
  input  logic             LOAD_REQ,
  input  logic             LOAD_DONE,
  output logic             LOAD_GNT,
  output logic             STRM_EN,
  input  logic             MON_TVALID,
  input  logic             MON_TREADY,
  input  logic             MON_TLAST,
  output logic             BUSY,
  output logic [CNT_W-1:0] FRAME_CNT,
  output logic             DONE,
  output logic             ERR
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_GAP} state_t;

  localparam logic [CNT_W-1:0] FRAME_LEN = CNT_W'(FRAME_WORDS);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] num_frames, gap_len, gap_cnt, beat_cnt;
  logic             start_pend, stop_flag, run_active;

  logic             beat, frame_end, stop_now, last_frame;
  logic             start_run, end_run;
  logic [CNT_W-1:0] frame_next, beat_next;

  assign beat       = (state == S_RUN) && MON_TVALID && MON_TREADY;
  assign frame_end  = beat && MON_TLAST;
  assign frame_next = FRAME_CNT + ONE;
  assign beat_next  = beat_cnt + ONE;
  // A stop request arriving in the same cycle as a boundary takes effect at once.
  assign stop_now   = stop_flag || CFG_STOP;
  assign last_frame = stop_now || ((num_frames != '0) && (frame_next == num_frames));

  always_comb begin
    state_nxt = state;
    start_run = 1'b0;
    end_run   = 1'b0;
    case (state)
      S_IDLE: begin
        if (LOAD_REQ) begin
          state_nxt = S_LOAD;
        end else if (CFG_START) begin
          state_nxt = S_RUN;
          start_run = 1'b1;
        end
      end
      S_LOAD: begin
        if (LOAD_DONE) begin
          if (run_active) begin
            if (stop_now) begin
              state_nxt = S_IDLE;
              end_run   = 1'b1;
            end else begin
              state_nxt = (gap_len != '0) ? S_GAP : S_RUN;
            end
          end else if (start_pend) begin
            state_nxt = S_RUN;
            start_run = 1'b1;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      S_RUN: begin
        if (frame_end) begin
          if (last_frame) begin
            state_nxt = S_IDLE;
            end_run   = 1'b1;
          end else if (LOAD_REQ) begin
            state_nxt = S_LOAD;
          end else if (gap_len != '0) begin
            state_nxt = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (stop_now) begin
          state_nxt = S_IDLE;
          end_run   = 1'b1;
        end else if (LOAD_REQ) begin
          state_nxt = S_LOAD;
        end else if (gap_cnt == ONE) begin
          state_nxt = S_RUN;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state      <= S_IDLE;
      STRM_EN    <= 1'b0;
      LOAD_GNT   <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      ERR        <= 1'b0;
      FRAME_CNT  <= '0;
      beat_cnt   <= '0;
      gap_cnt    <= '0;
      num_frames <= '0;
      gap_len    <= '0;
      start_pend <= 1'b0;
      stop_flag  <= 1'b0;
      run_active <= 1'b0;
    end else begin
      state    <= state_nxt;
      STRM_EN  <= (state_nxt == S_RUN);
      LOAD_GNT <= (state_nxt == S_LOAD);
      BUSY     <= (state_nxt != S_IDLE);
      DONE     <= end_run;

      if (start_run) begin
        num_frames <= CFG_NUM_FRAMES;
        gap_len    <= CFG_GAP;
        FRAME_CNT  <= '0;
        beat_cnt   <= '0;
        stop_flag  <= 1'b0;
        start_pend <= 1'b0;
        run_active <= 1'b1;
      end else begin
        if ((state == S_IDLE) && LOAD_REQ && CFG_START)
          start_pend <= 1'b1;
        if (end_run) begin
          run_active <= 1'b0;
          stop_flag  <= 1'b0;
        end else if ((state != S_IDLE) && CFG_STOP) begin
          stop_flag <= 1'b1;
        end
        if (beat) begin
          if (MON_TLAST) begin
            beat_cnt  <= '0;
            FRAME_CNT <= frame_next;
            if (beat_next != FRAME_LEN)
              ERR <= 1'b1;
          end else begin
            beat_cnt <= beat_next;
          end
        end
      end

      // Gap timer: loaded on entry, leaves GAP at terminal count 1.
      if ((state_nxt == S_GAP) && (state != S_GAP))
        gap_cnt <= gap_len;
      else if (state == S_GAP)
        gap_cnt <= gap_cnt - ONE;
    end
  end

endmodule

// File: doc/frame_scheduler.md
FRAME_SCHEDULER -- requirements
Module: frame_scheduler

Interface
REQ-001 SHALL have parameter FRAME_WORDS, default 1040, meaning beats per frame (1024 data + 16 zero pad).
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of the frame-count, gap and beat counters.
REQ-003 SHALL have port ACLK  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port ARESET  input  1  synchronous, active-high reset.
REQ-005 SHALL have port CFG_START  input  1  single-cycle start request.
REQ-006 SHALL have port CFG_STOP  input  1  single-cycle request to stop at the next frame boundary.
REQ-007 SHALL have port CFG_NUM_FRAMES  input  CNT_W  frames per run; 0 = continuous.
REQ-008 SHALL have port CFG_GAP  input  CNT_W  idle cycles between frames.
REQ-009 SHALL have port LOAD_REQ  input  1  BRAM loader requests exclusive BRAM access (level).
REQ-010 SHALL have port LOAD_DONE  input  1  loader finished; single-cycle pulse.
REQ-011 SHALL have port LOAD_GNT  output  1  loader owns BRAM.
REQ-012 SHALL have port STRM_EN  output  1  enables the BRAM-to-stream datapath.
REQ-013 SHALL have ports MON_TVALID, MON_TREADY, MON_TLAST  input  1 each  monitored stream handshake.
REQ-014 SHALL have port BUSY  output  1  high in any state other than IDLE.
REQ-015 SHALL have port FRAME_CNT  output  CNT_W  frames completed in the current run.
REQ-016 SHALL have port DONE  output  1  single-cycle pulse when a run ends.
REQ-017 SHALL have port ERR  output  1  sticky frame-length error.

Function
REQ-018 SHALL implement states IDLE, LOAD, RUN and GAP; all outputs SHALL be registered.
REQ-019 SHALL count a beat in RUN only when MON_TVALID and MON_TREADY are both high.
REQ-020 IDLE: LOAD_REQ SHALL move to LOAD; otherwise CFG_START SHALL move to RUN. If both are high, LOAD SHALL win and the start SHALL be latched as pending.
REQ-021 On entry to RUN from IDLE: CFG_NUM_FRAMES and CFG_GAP SHALL be captured; FRAME_CNT, the beat counter and the stop flag SHALL be cleared.
REQ-022 LOAD: LOAD_GNT=1 and STRM_EN=0. On LOAD_DONE: go to GAP if a run is active, else to RUN if a start is pending, else to IDLE. LOAD_GNT SHALL drop in the same cycle as the exit.
REQ-023 RUN: STRM_EN=1. A counted beat with MON_TLAST=1 SHALL complete the frame.
REQ-024 At frame completion: FRAME_CNT SHALL increment; the beat counter SHALL reset to 0.
REQ-025 At frame completion: ERR SHALL set if the beat count including the last beat is not FRAME_WORDS.
REQ-026 Exit priority at frame completion, highest first:
  (a) stop flag set, or captured NUM_FRAMES nonzero and the new FRAME_CNT equals it: go to IDLE and pulse DONE for one cycle.
  (b) LOAD_REQ high: go to LOAD.
  (c) captured gap nonzero: go to GAP.
  (d) otherwise: stay in RUN.
REQ-027 LOAD_REQ in the middle of a frame SHALL NOT be granted before the frame boundary.
REQ-028 GAP: STRM_EN=0; exactly the captured gap count of cycles SHALL elapse, then RUN. LOAD_REQ during GAP SHALL move to LOAD, abandoning the remaining gap.
REQ-029 CFG_STOP in RUN, GAP or LOAD SHALL set the stop flag.
REQ-030 With the stop flag set, a run SHALL end at the next frame completion. From GAP or LOAD with the stop flag set, it SHALL go to IDLE with DONE, without starting a new frame.
REQ-031 CFG_START while BUSY and CFG_STOP in IDLE SHALL be ignored.
REQ-032 STRM_EN SHALL rise in the first cycle after entering RUN. It SHALL fall in the first cycle after the completing beat.
REQ-033 FRAME_CNT SHALL wrap modulo 2^CNT_W in continuous mode.
REQ-034 FRAME_CNT SHALL hold its value in IDLE until the next start.
REQ-035 ERR SHALL clear only on reset.

Reset
REQ-036 With ARESET high at a clock edge, the block SHALL go to IDLE.
REQ-037 That reset SHALL clear STRM_EN, LOAD_GNT, BUSY, DONE, ERR, FRAME_CNT, all counters, and the pending-start and stop flags to 0.
REQ-038 Reset SHALL take effect mid-frame or mid-load, with no DONE pulse generated.

Verification
REQ-039 NUM_FRAMES=2, GAP=4, FRAME_WORDS=1040, TREADY always high -> STRM_EN high for 1040 cycles, low 4, high 1040; DONE pulses once; FRAME_CNT=2; ERR=0.
REQ-040 LOAD_REQ raised at beat 500 of frame 1 -> LOAD_GNT=1 only after the beat-1040 TLAST; LOAD_DONE -> gap (GAP>0) then RUN.
REQ-041 NUM_FRAMES=0, CFG_STOP at beat 10 of frame 3 -> frame 3 finishes all 1040 beats; then IDLE; DONE pulse; FRAME_CNT=3.
REQ-042 TLAST injected at beat 1000 -> ERR=1 and stays 1 through subsequent frames until ARESET.
REQ-043 CFG_START and LOAD_REQ in the same cycle from IDLE -> LOAD first; LOAD_DONE -> RUN with no second start pulse.
REQ-044 ARESET asserted mid-frame -> next cycle all outputs 0, state IDLE; a new CFG_START runs normally.
